vic_wb: RTL and testbench

- Vectored interrupt controller that sits directly upstream of the processor module's interrupt inputs (virq, ivec, istb, iack).
- Collects level interrupt requests from up to four peripheral channels and raises a single virq to the CPU.
- On the CPU's vector-fetch strobe it arbitrates by fixed priority, returns the winning channel's vector with iack, and pulses an acknowledge back to that device so it drops its request.

---
 rtl/vic_wb.sv | 86 ++++++++
 tb/tb_vic_wb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vic_wb.sv
// Four-channel vectored interrupt controller: raises virq, answers the CPU's
// istb vector fetch with a fixed-priority vector and acks the granted device.
module vic_wb #(
    parameter logic [15:0] VEC0     = 16'o000060,
    parameter logic [15:0] VEC1     = 16'o000064,
    parameter logic [15:0] VEC2     = 16'o000100,
    parameter logic [15:0] VEC3     = 16'o000220,
    parameter logic [15:0] SPUR_VEC = 16'o000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [3:0]  irq,
    output logic [3:0]  irq_ack,
    output logic        virq,
    input  logic        istb,
    output logic [15:0] ivec,
    output logic        iack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t state;

    // Lowest index wins; no request pending yields the spurious vector.
    function automatic logic [15:0] pick_vec(input logic [3:0] req);
        if (req[0])      return VEC0;
        else if (req[1]) return VEC1;
        else if (req[2]) return VEC2;
        else if (req[3]) return VEC3;
        else             return SPUR_VEC;
    endfunction

    function automatic logic [3:0] pick_grant(input logic [3:0] req);
        return req & (~req + 4'd1);
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            virq    <= 1'b0;
            iack    <= 1'b0;
            ivec    <= 16'o0;
            irq_ack <= 4'b0;
        end else begin
            irq_ack <= 4'b0;
            case (state)
                IDLE: begin
                    if (|irq) begin
                        state <= REQ;
                        virq  <= 1'b1;
                    end
                end
                REQ: begin
                    if (istb) begin
                        state   <= ACK;
                        virq    <= 1'b0;
                        iack    <= 1'b1;
                        ivec    <= pick_vec(irq);
                        irq_ack <= pick_grant(irq);
                    end else if (irq == 4'b0) begin
                        state <= IDLE;
                        virq  <= 1'b0;
                    end
                end
                ACK: begin
                    if (!istb) begin
                        state <= GUARD;
                        iack  <= 1'b0;
                        ivec  <= 16'o0;
                    end
                end
                GUARD: begin
                    // One dead cycle lets the acked device drop its level.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vic_wb.sv
// Directed bench for vic_wb: reset, single request, priority, withdrawal,
// spurious fetch and a stuck device.
module tb_vic_wb;

    logic        clk_p = 1'b0;
    logic        rst   = 1'b1;
    logic [3:0]  irq   = 4'b0;
    logic        istb  = 1'b0;
    logic [3:0]  irq_ack;
    logic        virq;
    logic [15:0] ivec;
    logic        iack;

    int checks   = 0;
    int failures = 0;

    vic_wb dut (
        .wb_clk_i (clk_p),
        .wb_rst_i (rst),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .virq     (virq),
        .istb     (istb),
        .ivec     (ivec),
        .iack     (iack)
    );

    always #5 clk_p = ~clk_p;

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic a,
                             input logic [15:0] vec, input logic [3:0] ack);
        check({tag, "_virq"}, {15'b0, virq}, {15'b0, v});
        check({tag, "_iack"}, {15'b0, iack}, {15'b0, a});
        check({tag, "_ivec"}, ivec, vec);
        check({tag, "_irq_ack"}, {12'b0, irq_ack}, {12'b0, ack});
    endtask

    initial begin
        // Power-on reset
        tick(); tick();
        check_all("reset", 1'b0, 1'b0, 16'o0, 4'b0);
        rst = 1'b0;
        tick();
        check_all("idle_after_reset", 1'b0, 1'b0, 16'o0, 4'b0);

        // Single request on channel 2
        irq = 4'b0100;                         // cycle 0
        tick();                                // cycle 1
        check_all("single_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        tick();                                // cycle 2
        tick();                                // cycle 3
        istb = 1'b1;
        tick();                                // cycle 4
        check_all("single_ack", 1'b0, 1'b1, 16'o000100, 4'b0100);
        irq = 4'b0;
        tick();                                // cycle 5
        check_all("single_ack_hold", 1'b0, 1'b1, 16'o000100, 4'b0);
        tick();                                // cycle 6
        istb = 1'b0;
        tick();                                // cycle 7
        check_all("single_iack_low", 1'b0, 1'b0, 16'o0, 4'b0);
        tick(); tick();
        check_all("single_quiet", 1'b0, 1'b0, 16'o0, 4'b0);

        // Higher priority arriving while in REQ wins at the istb sample
        irq = 4'b1000;
        tick();
        check_all("prio_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        irq = 4'b1001;
        tick();
        istb = 1'b1;
        tick();
        check_all("prio_ch0", 1'b0, 1'b1, 16'o000060, 4'b0001);
        irq  = 4'b1000;
        istb = 1'b0;
        tick();
        check_all("prio_guard", 1'b0, 1'b0, 16'o0, 4'b0);
        tick();
        check_all("prio_idle", 1'b0, 1'b0, 16'o0, 4'b0);
        tick();
        check_all("prio_revirq", 1'b1, 1'b0, 16'o0, 4'b0);
        istb = 1'b1;
        tick();
        check_all("prio_ch3", 1'b0, 1'b1, 16'o000220, 4'b1000);
        irq  = 4'b0;
        istb = 1'b0;
        tick(); tick(); tick();
        check_all("prio_quiet", 1'b0, 1'b0, 16'o0, 4'b0);

        // Withdrawn request
        irq = 4'b0010;
        tick();
        check_all("wd_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        irq = 4'b0;
        tick();
        check_all("wd_drop", 1'b0, 1'b0, 16'o0, 4'b0);
        tick();
        check_all("wd_quiet", 1'b0, 1'b0, 16'o0, 4'b0);

        // Spurious fetch: request drops as istb rises
        irq = 4'b0100;
        tick();
        check_all("spur_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        irq  = 4'b0;
        istb = 1'b1;
        tick();
        check_all("spur_ack", 1'b0, 1'b1, 16'o000000, 4'b0);
        istb = 1'b0;
        tick();
        check_all("spur_guard", 1'b0, 1'b0, 16'o0, 4'b0);
        tick();

        // Stuck device re-raises virq two clocks after each iack fall
        irq = 4'b0001;
        tick();
        check_all("stuck_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        for (int i = 0; i < 3; i++) begin
            istb = 1'b1;
            tick();
            check_all("stuck_ack", 1'b0, 1'b1, 16'o000060, 4'b0001);
            tick();
            check_all("stuck_hold", 1'b0, 1'b1, 16'o000060, 4'b0);
            istb = 1'b0;
            tick();
            check_all("stuck_guard", 1'b0, 1'b0, 16'o0, 4'b0);
            tick();
            check_all("stuck_idle", 1'b0, 1'b0, 16'o0, 4'b0);
            tick();
            check_all("stuck_revirq", 1'b1, 1'b0, 16'o0, 4'b0);
        end

        // Reset mid-ACK with istb held high
        istb = 1'b1;
        tick();
        check_all("rst_pre_ack", 1'b0, 1'b1, 16'o000060, 4'b0001);
        rst = 1'b1;
        tick();
        check_all("rst_mid_ack", 1'b0, 1'b0, 16'o0, 4'b0);
        irq  = 4'b0;
        istb = 1'b0;
        rst  = 1'b0;
        tick(); tick(); tick();
        check_all("rst_idle", 1'b0, 1'b0, 16'o0, 4'b0);

        // Reset on the same edge istb is sampled: no ack for the aborted cycle
        irq = 4'b0010;
        tick();
        check_all("rst2_virq", 1'b1, 1'b0, 16'o0, 4'b0);
        istb = 1'b1;
        rst  = 1'b1;
        tick();
        check_all("rst2_abort", 1'b0, 1'b0, 16'o0, 4'b0);
        irq  = 4'b0;
        istb = 1'b0;
        rst  = 1'b0;
        tick(); tick();
        check_all("rst2_idle", 1'b0, 1'b0, 16'o0, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
